// File: rtl/sync_frame_controller_if.sv
// ============================================================================
// sync_frame_controller_if : byte-bus / payload-stream bundle for the frame sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sync_frame_controller_if #(
   parameter int CNT_W = 16
);
   logic [7:0]       data;
   logic             det_flag;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_first;
   logic             out_last;
   logic [7:0]       frame_len;
   logic             frame_done;
   logic             frame_ok;
   logic             busy;
   logic [CNT_W-1:0] ok_count;
   logic [CNT_W-1:0] err_count;

   // master: byte source / detector side and packet consumer
   modport master (
      output data, det_flag,
      input  out_data, out_valid, out_first, out_last,
      input  frame_len, frame_done, frame_ok, busy, ok_count, err_count
   );

   // slave: the frame controller itself
   modport slave (
      input  data, det_flag,
      output out_data, out_valid, out_first, out_last,
      output frame_len, frame_done, frame_ok, busy, ok_count, err_count
   );
endinterface

`default_nettype wire

// File: rtl/sync_frame_controller.sv
// ============================================================================
// sync_frame_controller : length/payload/XOR-checksum framer behind the sync detector
// Optional statistics counters enabled by macro SYNC_FRAME_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_frame_controller #(
   parameter int MAX_LEN = 32,
   parameter int CNT_W   = 16
) (
   input  wire logic clk,
   input  wire logic nrst,
   sync_frame_controller_if.slave bus
);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CSUM    = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] xor_q, xor_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic       out_first_q, out_first_d;
   logic       out_last_q, out_last_d;
   logic [7:0] frame_len_q, frame_len_d;
   logic       frame_done_q, frame_done_d;
   logic       frame_ok_q, frame_ok_d;
   logic       busy_q, busy_d;
   logic       len_bad;
   logic       last_byte;

   assign len_bad   = (bus.data == 8'd0) || ({1'b0, bus.data} > 9'(MAX_LEN));
   assign last_byte = (cnt_q == frame_len_q - 8'd1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      xor_d        = xor_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      out_first_d  = 1'b0;
      out_last_d   = 1'b0;
      frame_len_d  = frame_len_q;
      frame_done_d = 1'b0;
      frame_ok_d   = frame_ok_q;
      case (state_q)
         HUNT: begin
            if (bus.det_flag) begin
               frame_len_d = bus.data;
               if (len_bad) begin
                  frame_done_d = 1'b1;
                  frame_ok_d   = 1'b0;
               end else begin
                  cnt_d   = 8'd0;
                  xor_d   = 8'd0;
                  state_d = PAYLOAD;
               end
            end
         end
         // det_flag is deliberately not looked at here: payload may contain the sync word
         PAYLOAD: begin
            out_data_d  = bus.data;
            out_valid_d = 1'b1;
            out_first_d = (cnt_q == 8'd0);
            out_last_d  = last_byte;
            xor_d       = xor_q ^ bus.data;
            cnt_d       = cnt_q + 8'd1;
            if (last_byte) begin
               state_d = CSUM;
            end
         end
         CSUM: begin
            frame_done_d = 1'b1;
            frame_ok_d   = (bus.data == xor_q);
            state_d      = HUNT;
         end
         default: state_d = HUNT;
      endcase
      busy_d = (state_d != HUNT);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= HUNT;
         cnt_q        <= 8'd0;
         xor_q        <= 8'd0;
         out_data_q   <= 8'd0;
         out_valid_q  <= 1'b0;
         out_first_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_len_q  <= 8'd0;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         xor_q        <= xor_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_first_q  <= out_first_d;
         out_last_q   <= out_last_d;
         frame_len_q  <= frame_len_d;
         frame_done_q <= frame_done_d;
         frame_ok_q   <= frame_ok_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_first  = out_first_q;
   assign bus.out_last   = out_last_q;
   assign bus.frame_len  = frame_len_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_ok   = frame_ok_q;
   assign bus.busy       = busy_q;

`ifdef SYNC_FRAME_STATS_EN
   logic [CNT_W-1:0] ok_count_q, ok_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   // Counters move with the registered frame_done, and stick at all-ones
   always_comb begin
      ok_count_d  = ok_count_q;
      err_count_d = err_count_q;
      if (frame_done_d && frame_ok_d && (ok_count_q != {CNT_W{1'b1}})) begin
         ok_count_d = ok_count_q + 1'b1;
      end
      if (frame_done_d && !frame_ok_d && (err_count_q != {CNT_W{1'b1}})) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ok_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         ok_count_q  <= ok_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.ok_count  = ok_count_q;
   assign bus.err_count = err_count_q;
`else
   assign bus.ok_count  = '0;
   assign bus.err_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/sync_frame_controller.md
Name: sync_frame_controller

Overview:
- Frame sequencer behind sequence_detection_unit, which raises flag for one cycle after it has sampled the sync word AB CD EF 24.
- Takes that flag plus the same raw byte bus, then captures a length byte, a payload of that length and an XOR checksum byte.
- Streams the payload downstream, reports each frame as ok or error, and re-arms hunting.
- Sits between the byte source/detector pair and the packet consumer.

Parameters:
MAX_LEN, 32, largest legal payload length in bytes (legal range 1..255).
CNT_W, 16, width of the ok/error frame statistics counters.

Ports:
clk  input  1  clock; all logic on rising edge.
nrst  input  1  asynchronous active-low reset.
data  input  8  raw byte bus; one byte every clk, same bus that feeds the detector.
det_flag  input  1  detector flag; high in cycle t means bytes at t-4..t-1 were AB,CD,EF,24.
out_data  output  8  payload byte, registered.
out_valid  output  1  out_data holds a payload byte this cycle.
out_first  output  1  with out_valid: first payload byte of the frame.
out_last  output  1  with out_valid: last payload byte of the frame.
frame_len  output  8  length of the current/last frame, held until the next length capture.
frame_done  output  1  one-cycle pulse: frame finished (ok or error).
frame_ok  output  1  qualifies frame_done: 1 = checksum matched; holds until the next frame_done.
busy  output  1  high whenever state is not HUNT.
ok_count  output  CNT_W  frames ending with frame_ok=1 (only with the optional feature).
err_count  output  CNT_W  frames ending in error (only with the optional feature).

Behaviour:
- Reset (async, nrst low):
  - State HUNT; byte counter and running XOR cleared.
  - out_data=0, out_valid=0, out_first=0, out_last=0, frame_len=0, frame_done=0, frame_ok=0, busy=0, counters=0.
- Reset mid-frame aborts the frame with no frame_done; the partial frame is neither counted nor flagged.
- State HUNT:
  - det_flag=0: stay in HUNT.
  - det_flag=1: the current data byte is the length L; latch L into frame_len.
  - L==0 or L>MAX_LEN: frame_done=1, frame_ok=0 next cycle; err_count+1; stay in HUNT.
  - Otherwise: clear the running XOR and byte counter, go to PAYLOAD.
- State PAYLOAD:
  - Each cycle: out_data<=data, out_valid<=1, XOR<=XOR^data, counter+1.
  - out_first is set on the byte with counter==0; out_last on the byte with counter==L-1.
  - After byte L-1, go to CSUM.
  - det_flag is ignored, so a payload containing AB CD EF 24 does not restart framing.
- State CSUM:
  - The data byte is compared with the running XOR.
  - Next cycle: frame_done=1, frame_ok=(match); the matching counter increments. Go to HUNT.
- Latency:
  - Payload byte sampled in cycle c appears on out_* in cycle c+1.
  - frame_done follows the checksum byte by 1 cycle, or the bad length byte by 1 cycle.
- Back-to-back frames:
  - det_flag in the cycle right after CSUM (HUNT) is accepted.
  - The cycle of frame_done may coincide with the length capture of the next frame.
- det_flag is only honoured in HUNT. Flags arriving in LEN-equivalent, PAYLOAD or CSUM cycles are dropped.
- out_valid, frame_done and out_first/out_last are 0 in every cycle they are not explicitly asserted.
- Output handshake: none; the consumer must accept one byte per cycle.
- Arithmetic:
  - Byte counter is 8 bits and compared against L-1.
  - Checksum is an 8-bit XOR of payload bytes only; the length byte is excluded.
- Counters saturate at all-ones and do not wrap.
- busy is registered and is 1 from the cycle after length capture through the CSUM cycle.

Optional Feature:
- Macro SYNC_FRAME_STATS_EN.
- Defined: ok_count and err_count are implemented as saturating CNT_W counters, updated on frame_done.
- Undefined: both ports are tied to 0 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Bytes AB CD EF 24 03 11 22 33 00 (XOR 11^22^33=00), det_flag high on the 03 cycle:
  - out_data 11,22,33 on consecutive cycles with out_first on 11 and out_last on 33.
  - frame_len=3; frame_done=1, frame_ok=1 one cycle after byte 00; ok_count=1.
- Same frame with checksum byte 5A -> frame_done=1, frame_ok=0; err_count=1; payload still streamed.
- Length byte 00 -> frame_done=1, frame_ok=0 next cycle, no out_valid. Length 21h with MAX_LEN=32 -> same error.
- Payload AB CD EF 24 with L=4, det_flag pulsing mid-payload -> flag ignored; checksum XOR=24^...=the 4-byte XOR accepted; no restart.
- Two frames back-to-back, second det_flag in the cycle after the first CSUM -> both frames ok; ok_count=2.
- nrst low during byte 2 of a 5-byte payload -> all outputs 0, no frame_done, counters unchanged; next sync frame captured normally.
